// File: rtl/opb_reg_pkg.sv
// Shared types and helpers for the OPB software-register slaves.
package opb_reg_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, HOLD = 2'd2} state_t;

  localparam int OFF_DATA   = 0;
  localparam int OFF_STATUS = 1;

  // OPB numbers bits from the MSB (bit 0); user side numbers from the LSB.
  function automatic logic [31:0] bit_rev_in(input logic [0:31] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = d[i];
    return r;
  endfunction

  function automatic logic [0:31] bit_rev_out(input logic [31:0] u);
    logic [0:31] r;
    for (int i = 0; i < 32; i++) r[i] = u[31-i];
    return r;
  endfunction

  // BE[k] owns user byte [31-8k : 24-8k].
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [0:3]  be);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++)
      if (be[k]) r[31-8*k -: 8] = new_v[31-8*k -: 8];
    return r;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Address-window decode and IDLE/ACK/HOLD handshake for a single-word-ack OPB slave.
module opb_slave_ack_fsm
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  localparam int         OW           = C_OPB_AWIDTH - 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [0:C_OPB_AWIDTH-1] i_abus,
  input  logic                    i_rnw,
  input  logic                    i_select,
  output logic                    o_start,
  output logic [OW-1:0]           o_off,
  output logic                    o_ack,
  output logic                    o_wr_stb
);

  localparam logic [C_OPB_AWIDTH-1:0] LP_BASE = C_BASEADDR[C_OPB_AWIDTH-1:0];
  localparam logic [C_OPB_AWIDTH-1:0] LP_SPAN = C_HIGHADDR[C_OPB_AWIDTH-1:0] - LP_BASE;

  state_t                  r_state, w_nxt;
  logic [C_OPB_AWIDTH-1:0] w_rel;
  logic                    w_hit;
  logic                    r_ack, r_wr_stb;
  logic                    w_unused_lsb;

  // Below-base addresses wrap to a large offset and fall outside the span.
  assign w_rel        = i_abus - LP_BASE;
  assign w_hit        = i_select && (w_rel <= LP_SPAN);
  assign w_unused_lsb = ^w_rel[1:0];

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nxt;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_hit) w_nxt = ACK;
      ACK:     w_nxt = HOLD;
      HOLD:    if (!i_select) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_start = (r_state == IDLE) && w_hit;
    o_off   = w_rel[C_OPB_AWIDTH-1:2];
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_ack    <= 1'b0;
      r_wr_stb <= 1'b0;
    end else begin
      r_ack    <= o_start;
      r_wr_stb <= o_start && !i_rnw && (o_off == OW'(OFF_DATA));
    end

  assign o_ack    = r_ack;
  assign o_wr_stb = r_wr_stb;

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// OPB write-direction software register: PPC-written data word, update strobe, write counter.
module opb_register_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_INIT_VALUE = 32'h0000_0000
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [31:0]               user_data_out,
  output logic                      user_data_valid
);

  localparam int OW = C_OPB_AWIDTH - 2;

  logic          w_start, w_ack, w_wr_stb, w_wr_data;
  logic [OW-1:0] w_off;
  logic [31:0]   r_data, r_rd, w_rd_mux;
  logic [15:0]   r_cnt;
  logic          w_unused;

  assign w_unused = OPB_seqAddr;

  opb_slave_ack_fsm #(
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR),
    .C_OPB_AWIDTH (C_OPB_AWIDTH)
  ) u_fsm (
    .i_clk    (OPB_Clk),
    .i_rst_n  (OPB_Rst_n),
    .i_abus   (OPB_ABus),
    .i_rnw    (OPB_RNW),
    .i_select (OPB_select),
    .o_start  (w_start),
    .o_off    (w_off),
    .o_ack    (w_ack),
    .o_wr_stb (w_wr_stb)
  );

  assign w_wr_data = w_start && !OPB_RNW && (w_off == OW'(OFF_DATA));

  always_comb begin
    w_rd_mux = '0;
    if (w_off == OW'(OFF_DATA))        w_rd_mux = r_data;
    else if (w_off == OW'(OFF_STATUS)) w_rd_mux = {16'h0000, r_cnt};
  end

  // Read data is captured only on the start edge, so it is nonzero only while acking.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n)
    if (!OPB_Rst_n) begin
      r_data <= C_INIT_VALUE;
      r_cnt  <= '0;
      r_rd   <= '0;
    end else begin
      r_rd <= (w_start && OPB_RNW) ? w_rd_mux : '0;
      if (w_wr_data) begin
        r_data <= byte_merge(r_data, bit_rev_in(OPB_DBus), OPB_BE);
        r_cnt  <= r_cnt + 16'd1;
      end
    end

  assign Sl_DBus         = bit_rev_out(r_rd);
  assign Sl_xferAck      = w_ack;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = r_data;
  assign user_data_valid = w_wr_stb;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Directed plus randomized bench for opb_register_ppc2simulink against a word-level model.
module tb_opb_register_ppc2simulink;

  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam logic [31:0] HIGH = 32'h0000_20FF;
  localparam logic [31:0] INIT = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] abus = '0;
  logic [0:3]  be = '0;
  logic [0:31] dbus = '0;
  logic        rnw = 1'b0, sel = 1'b0, seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        sl_ack, sl_err, sl_retry, sl_tout;
  logic [31:0] udo;
  logic        uvld;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] m_data = INIT;
  logic [15:0] m_cnt = '0;

  always #5 clk = ~clk;

  opb_register_ppc2simulink #(
    .C_BASEADDR (BASE), .C_HIGHADDR (HIGH),
    .C_OPB_AWIDTH (32), .C_OPB_DWIDTH (32), .C_INIT_VALUE (INIT)
  ) dut (
    .OPB_Clk (clk), .OPB_Rst_n (rst_n), .OPB_ABus (abus), .OPB_BE (be),
    .OPB_DBus (dbus), .OPB_RNW (rnw), .OPB_select (sel), .OPB_seqAddr (seq),
    .Sl_DBus (sl_dbus), .Sl_xferAck (sl_ack), .Sl_errAck (sl_err),
    .Sl_retry (sl_retry), .Sl_toutSup (sl_tout),
    .user_data_out (udo), .user_data_valid (uvld)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One OPB transfer with select held for 'hold' cycles; checks ack/valid/data against the model.
  task automatic xfer(input string tag, input logic [31:0] addr, input bit rd,
                      input logic [3:0] be_v, input logic [31:0] d, input int hold);
    bit          hit, is_wr0;
    int          off, acks, vlds, first;
    logic [31:0] exp_rd, got_rd, udo0, mask;
    bit          dbus_leak;
    hit    = (addr >= BASE) && (addr <= HIGH);
    off    = int'((addr - BASE) >> 2);
    is_wr0 = hit && !rd && (off == 0);
    exp_rd = '0;
    if (hit && rd) exp_rd = (off == 0) ? m_data : (off == 1) ? {16'h0000, m_cnt} : 32'h0;
    if (is_wr0) begin
      mask = '0;
      for (int k = 0; k < 4; k++) if (be_v[3-k]) mask = mask | (32'hFF << (24 - 8*k));
      m_data = (m_data & ~mask) | (d & mask);
      m_cnt  = m_cnt + 16'd1;
    end
    acks = 0; vlds = 0; first = -1; got_rd = '0; udo0 = '0; dbus_leak = 1'b0;
    @(negedge clk);
    abus = addr; rnw = rd; be = be_v; dbus = d; sel = 1'b1;
    for (int c = 0; c < hold + 3; c++) begin
      @(negedge clk);
      if (c == 0) udo0 = udo;
      if (sl_ack) begin
        acks++;
        if (first < 0) first = c;
        got_rd = sl_dbus;
      end else if (sl_dbus !== '0) dbus_leak = 1'b1;
      if (uvld) vlds++;
      if (c == hold - 1) sel = 1'b0;
    end
    chk({tag, ":acks"}, 32'(acks), 32'(hit));
    chk({tag, ":valids"}, 32'(vlds), 32'(is_wr0));
    chk({tag, ":dbus_idle"}, 32'(dbus_leak), 32'd0);
    if (hit) chk({tag, ":ack_cycle"}, 32'(first), 32'd0);
    if (hit && rd) chk({tag, ":rdata"}, got_rd, exp_rd);
    if (is_wr0) chk({tag, ":udo_at_ack"}, udo0, m_data);
    chk({tag, ":udo"}, udo, m_data);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset:udo", udo, INIT);
    chk("reset:sl", {27'h0, sl_ack, sl_err, sl_retry, sl_tout, uvld}, 32'h0);
    chk("reset:dbus", sl_dbus, 32'h0);
    rst_n = 1'b1;

    xfer("rd_cnt0", BASE + 4, 1'b1, 4'hF, 32'h0, 1);
    xfer("wr_full", BASE, 1'b0, 4'b1111, 32'hDEAD_BEEF, 1);
    xfer("rd_full", BASE, 1'b1, 4'hF, 32'h0, 1);
    xfer("wr_be0100", BASE, 1'b0, 4'b0100, 32'h00AA_0000, 1);
    chk("wr_be0100:const", udo, 32'hDEAA_BEEF);
    xfer("rd_cnt2", BASE + 4, 1'b1, 4'hF, 32'h0, 1);
    xfer("wr_hold5", BASE, 1'b0, 4'b1111, 32'h0BAD_CAFE, 5);
    xfer("rd_hold5", BASE, 1'b1, 4'hF, 32'h0, 5);
    xfer("miss_high", HIGH + 1 + 3, 1'b0, 4'hF, 32'hFFFF_FFFF, 2);
    xfer("miss_low", BASE - 4, 1'b1, 4'hF, 32'h0, 1);
    xfer("wr_word3", BASE + 12, 1'b0, 4'hF, 32'h5555_AAAA, 1);
    xfer("wr_status", BASE + 4, 1'b0, 4'hF, 32'hFFFF_FFFF, 1);
    xfer("wr_be0000", BASE, 1'b0, 4'b0000, 32'hFFFF_FFFF, 1);
    xfer("rd_cnt", BASE + 4, 1'b1, 4'hF, 32'h0, 2);
    xfer("rd_word3", BASE + 12, 1'b1, 4'hF, 32'h0, 1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0, 1:    a = BASE;
        2:       a = BASE + 4;
        3:       a = BASE + 4 * $urandom_range(2, 63);
        4:       a = HIGH + 1 + 4 * $urandom_range(0, 15);
        default: a = BASE - 4 * $urandom_range(1, 15);
      endcase
      xfer($sformatf("rnd%0d", i), a, 1'($urandom_range(0, 1)), 4'($urandom),
           $urandom, $urandom_range(1, 3));
    end

    // Counter wrap via a backdoor preset
    @(negedge clk);
    force dut.r_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_cnt;
    m_cnt = 16'hFFFF;
    xfer("wrap_pre", BASE + 4, 1'b1, 4'hF, 32'h0, 1);
    xfer("wrap_wr", BASE, 1'b0, 4'hF, 32'h0102_0304, 1);
    xfer("wrap_post", BASE + 4, 1'b1, 4'hF, 32'h0, 1);

    // Asynchronous reset while the ack is up
    @(negedge clk);
    abus = BASE; rnw = 1'b0; be = 4'hF; dbus = 32'hCAFE_F00D; sel = 1'b1;
    @(posedge clk); #2;
    chk("rst_mid:ack_up", 32'(sl_ack), 32'd1);
    rst_n = 1'b0; #1;
    chk("rst_mid:ack_drop", 32'(sl_ack), 32'd0);
    chk("rst_mid:valid", 32'(uvld), 32'd0);
    chk("rst_mid:udo", udo, INIT);
    m_data = INIT; m_cnt = '0;
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer("post_rst_cnt", BASE + 4, 1'b1, 4'hF, 32'h0, 1);
    xfer("post_rst_data", BASE, 1'b1, 4'hF, 32'h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
